// File: rtl/fix2float_pipe.sv
// Three-stage signed fixed-point to IEEE-754 binary32 converter with valid/ready
// handshakes, four rounding modes and inexact/zero flags.
module fix2float_pipe #(
    parameter int INT_BITS  = 4,
    parameter int FRAC_BITS = 30,
    localparam int W        = INT_BITS + FRAC_BITS + 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] fixed_i,
    input  logic [1:0]   rmode_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [31:0]  float_o,
    output logic         inexact_o,
    output logic         zero_o
);

    localparam int PW = 7;       // wide enough for a bit index up to 63
    localparam int NW = W + 26;  // room for 24-bit significand, guard and sticky when W is small

    typedef enum logic [1:0] {RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RDN = 2'b10, RM_RUP = 2'b11} rmode_e;

    logic adv;
    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    logic         s1_valid, s1_sign, s1_zero;
    rmode_e       s1_rmode;
    logic [W-1:0] s1_mag;
    logic         s2_valid, s2_sign, s2_zero;
    rmode_e       s2_rmode;
    logic [W-1:0] s2_norm;
    logic [7:0]   s2_exp;

    // Most-negative input negates to 2^(W-1), which fits as a W-bit unsigned magnitude.
    logic [W-1:0] abs_in;
    assign abs_in = fixed_i[W-1] ? (~fixed_i + W'(1)) : fixed_i;

    logic [PW-1:0] lead;
    logic [PW-1:0] shamt;
    logic [W-1:0]  norm_c;
    logic [7:0]    exp_c;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        lead = '0;
        for (int i = 0; i < W; i++) begin
            if (s1_mag[i]) lead = PW'(i);
        end
        shamt  = PW'(W - 1) - lead;
        norm_c = s1_mag << shamt;
        exp_c  = 8'(127 - FRAC_BITS + int'(lead));
    end

    logic [NW-1:0] ext;
    logic [23:0]   sig;
    logic          guard, sticky, inc;
    logic [24:0]   sum;
    logic [22:0]   mant;
    logic [7:0]    exp_r;

    always_comb begin
        ext    = {s2_norm, 26'b0};
        sig    = ext[NW-1 -: 24];
        guard  = ext[NW-25];
        sticky = |ext[NW-26:0];
        inc    = 1'b0;
        case (s2_rmode)
            RM_RNE: inc = guard && (sticky || sig[0]);
            RM_RTZ: inc = 1'b0;
            RM_RDN: inc = s2_sign && (guard || sticky);
            RM_RUP: inc = !s2_sign && (guard || sticky);
            default: inc = 1'b0;
        endcase
        sum   = {1'b0, sig} + 25'(inc);
        // A carry out of the significand renormalises by one: fraction becomes zero, exponent bumps.
        mant  = sum[24] ? sum[23:1] : sum[22:0];
        exp_r = s2_exp + 8'(sum[24]);
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_o <= 1'b0;
            float_o     <= '0;
            inexact_o   <= 1'b0;
            zero_o      <= 1'b0;
        end else if (adv) begin
            s1_valid    <= in_valid_i;
            s2_valid    <= s1_valid;
            out_valid_o <= s2_valid;
            if (s2_valid) begin
                float_o   <= s2_zero ? 32'h0 : {s2_sign, exp_r, mant};
                inexact_o <= !s2_zero && (guard || sticky);
                zero_o    <= s2_zero;
            end
        end
    end

    // NOTE: datapath registers carry no reset; their contents only matter when the matching valid is set.
    always_ff @(posedge clk_i) begin
        if (adv) begin
            s1_sign  <= fixed_i[W-1];
            s1_mag   <= abs_in;
            s1_zero  <= (fixed_i == '0);
            s1_rmode <= rmode_e'(rmode_i);
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_rmode <= s1_rmode;
            s2_norm  <= norm_c;
            s2_exp   <= exp_c;
        end
    end

endmodule

// File: tb/tb_fix2float_pipe.sv
// Directed bench for fix2float_pipe: scoreboard of constant expectations, back-pressure,
// mid-stream reset and a second instance with a different fixed-point format.
module tb_fix2float_pipe;

    localparam int W  = 35;
    localparam int W2 = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  fixed = '0;
    logic [1:0]    rmode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   float_o;
    logic          inexact;
    logic          zero;

    logic          in_valid2 = 1'b0;
    logic          in_ready2;
    logic [W2-1:0] fixed2 = '0;
    logic          out_valid2;
    logic [31:0]   float2;
    logic          inexact2;
    logic          zero2;

    always #5 clk = ~clk;

    fix2float_pipe #(.INT_BITS(4), .FRAC_BITS(30)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .fixed_i(fixed), .rmode_i(rmode), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .float_o(float_o), .inexact_o(inexact), .zero_o(zero)
    );

    fix2float_pipe #(.INT_BITS(15), .FRAC_BITS(16)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .fixed_i(fixed2), .rmode_i(2'b00), .out_valid_o(out_valid2), .out_ready_i(1'b1),
        .float_o(float2), .inexact_o(inexact2), .zero_o(zero2)
    );

    typedef struct packed {
        logic [31:0] f;
        logic        inex;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic        stall_q = 1'b0;
    logic [33:0] held = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one sample and records its expected result once the handshake is seen.
    task automatic send(input logic [W-1:0] d, input logic [1:0] rm,
                        input logic [31:0] ef, input logic ei, input logic ez);
        int k;
        @(posedge clk); #1;
        in_valid = 1'b1;
        fixed    = d;
        rmode    = rm;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("accept_wait", in_ready, 1);
        sb.push_back('{f: ef, inex: ei, zero: ez});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 64'(sb.size()), 0);
    endtask

    // Single sample with an open output: valid must appear on the third edge counting the accept edge.
    task automatic lat_test(input logic [W-1:0] d, input logic [31:0] ef);
        send(d, 2'b00, ef, 1'b0, 1'b0);
        idle();
        @(negedge clk); check("latency_e1", out_valid, 0);
        @(negedge clk); check("latency_e2", out_valid, 0);
        @(negedge clk); check("latency_e3", out_valid, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (stall_q) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {float_o, inexact, zero}, held);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_float", float_o, mon_e.f);
                    check("out_inexact", inexact, mon_e.inex);
                    check("out_zero", zero, mon_e.zero);
                end
            end
            stall_q <= out_valid && !out_ready;
            held    <= {float_o, inexact, zero};
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_float", float_o, 0);
        check("rst_inexact", inexact, 0);
        check("rst_zero", zero, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        lat_test(35'h0_4000_0000, 32'h3F800000);
        lat_test(35'h7_C000_0000, 32'hBF800000);
        lat_test(35'h0_0000_0001, 32'h30800000);
        lat_test(35'h4_0000_0000, 32'hC1800000);
        drain();

        send(35'h3_FFFF_FFFF, 2'b00, 32'h41800000, 1'b1, 1'b0);
        send(35'h3_FFFF_FFFF, 2'b01, 32'h417FFFFF, 1'b1, 1'b0);
        send(35'h3_FFFF_FFFF, 2'b10, 32'h417FFFFF, 1'b1, 1'b0);
        send(35'h3_FFFF_FFFF, 2'b11, 32'h41800000, 1'b1, 1'b0);
        send(35'h4_0000_0001, 2'b10, 32'hC1800000, 1'b1, 1'b0);
        send(35'h4_0000_0001, 2'b01, 32'hC17FFFFF, 1'b1, 1'b0);
        send(35'h0_0200_0002, 2'b00, 32'h3D000000, 1'b1, 1'b0);
        send(35'h0_0200_0006, 2'b00, 32'h3D000002, 1'b1, 1'b0);
        send(35'h0_0200_0000, 2'b00, 32'h3D000000, 1'b0, 1'b0);
        for (int m = 0; m < 4; m++) send('0, 2'(m), 32'h0, 1'b0, 1'b1);
        idle();
        drain();

        fork
            begin
                repeat (60) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            begin
                send(35'h0_4000_0000, 2'b00, 32'h3F800000, 1'b0, 1'b0);
                send(35'h7_C000_0000, 2'b00, 32'hBF800000, 1'b0, 1'b0);
                send(35'h3_FFFF_FFFF, 2'b01, 32'h417FFFFF, 1'b1, 1'b0);
                send(35'h4_0000_0001, 2'b10, 32'hC1800000, 1'b1, 1'b0);
                send(35'h0_0200_0002, 2'b00, 32'h3D000000, 1'b1, 1'b0);
                send(35'h0_0200_0006, 2'b00, 32'h3D000002, 1'b1, 1'b0);
                send('0, 2'b11, 32'h0, 1'b0, 1'b1);
                send(35'h0_0000_0001, 2'b00, 32'h30800000, 1'b0, 1'b0);
                idle();
            end
        join
        drain();

        out_ready = 1'b0;
        send(35'h0_4000_0000, 2'b00, 32'h3F800000, 1'b0, 1'b0);
        send(35'h7_C000_0000, 2'b00, 32'hBF800000, 1'b0, 1'b0);
        send(35'h4_0000_0000, 2'b00, 32'hC1800000, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 0);
        end

        @(posedge clk); #1;
        in_valid2 = 1'b1;
        fixed2    = 32'h0001_0000;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        check("w32_one_valid", out_valid2, 1);
        check("w32_one_float", float2, 32'h3F800000);
        check("w32_one_inexact", inexact2, 0);
        @(posedge clk); #1;
        in_valid2 = 1'b1;
        fixed2    = 32'h8000_0000;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        check("w32_minneg_valid", out_valid2, 1);
        check("w32_minneg_float", float2, 32'hC7000000);
        check("w32_minneg_zero", zero2, 0);
        check("w32_in_ready", in_ready2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
